// File: rtl/ama_riscv_writeback_pkg.sv
// Shared write-back codes and the MEM/WB pipeline register layout.
// Pure declarations; no timing, no flow control.
package ama_riscv_writeback_pkg;

   localparam logic [1:0] WB_SEL_ALU = 2'd0;
   localparam logic [1:0] WB_SEL_MEM = 2'd1;
   localparam logic [1:0] WB_SEL_PC4 = 2'd2;

   localparam logic [2:0] LOAD_LB  = 3'b000;
   localparam logic [2:0] LOAD_LH  = 3'b001;
   localparam logic [2:0] LOAD_LW  = 3'b010;
   localparam logic [2:0] LOAD_LBU = 3'b100;
   localparam logic [2:0] LOAD_LHU = 3'b101;

   localparam logic [4:0] RF_X0 = 5'd0;

   typedef struct packed {
      logic        valid;
      logic        rd_we;
      logic [4:0]  rd_addr;
      logic [1:0]  sel;
      logic [2:0]  funct3;
      logic [31:0] alu;
      logic [31:0] pc;
   } wb_reg_t;

endpackage

// File: rtl/ama_riscv_load_align.sv
// Load byte/half/word extraction and sign/zero extension; purely combinational.
// Zero latency; no flow control.
module ama_riscv_load_align
   import ama_riscv_writeback_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  offset,
   input  logic [31:0] rdata,
   output logic [31:0] data,
   output logic        misaligned
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[7:0];
      case (offset)
         2'd1:    byte_sel = rdata[15:8];
         2'd2:    byte_sel = rdata[23:16];
         2'd3:    byte_sel = rdata[31:24];
         default: byte_sel = rdata[7:0];
      endcase
      half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
   end

   always_comb begin
      data       = '0;
      misaligned = 1'b0;
      case (funct3)
         LOAD_LB:  data = {{24{byte_sel[7]}}, byte_sel};
         LOAD_LBU: data = {24'h0, byte_sel};
         LOAD_LH: begin
            data       = {{16{half_sel[15]}}, half_sel};
            misaligned = offset[0];
         end
         LOAD_LHU: begin
            data       = {16'h0, half_sel};
            misaligned = offset[0];
         end
         LOAD_LW: begin
            data       = rdata;
            misaligned = (offset != 2'd0);
         end
         default: data = '0;
      endcase
   end

endmodule

// File: rtl/ama_riscv_writeback.sv
// MEM/WB register, load alignment and write-back select driving the RF write port and bypass.
// One cycle from mem_* capture to rf_*; stall holds WB and freezes load data. Optional AMA_RISCV_WB_INSTRET_EN.
module ama_riscv_writeback
   import ama_riscv_writeback_pkg::*;
#(
   parameter int          XLEN     = 32,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall,
   input  logic            flush,
   input  logic            mem_valid,
   input  logic            mem_rd_we,
   input  logic [4:0]      mem_rd_addr,
   input  logic [1:0]      mem_wb_sel,
   input  logic [2:0]      mem_funct3,
   input  logic [XLEN-1:0] mem_alu_out,
   input  logic [XLEN-1:0] mem_pc,
   input  logic [XLEN-1:0] dmem_rdata,
   output logic            rf_we,
   output logic [4:0]      rf_addr_d,
   output logic [XLEN-1:0] rf_data_d,
   output logic            load_misaligned,
   output logic [63:0]     instret
);

   wb_reg_t     wb_q;
   logic        hold_valid;
   logic [31:0] hold_data;
   logic [31:0] load_rdata;
   logic [31:0] load_data;
   logic        load_mis_raw;
   logic        wb_is_load;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wb_q    <= '0;
         wb_q.pc <= RESET_PC;
      end else if (flush) begin
         wb_q    <= '0;
         wb_q.pc <= RESET_PC;
      end else if (!stall) begin
         wb_q <= '{valid: mem_valid, rd_we: mem_rd_we, rd_addr: mem_rd_addr,
                   sel: mem_wb_sel, funct3: mem_funct3, alu: mem_alu_out, pc: mem_pc};
      end
   end

   assign wb_is_load = wb_q.valid & (wb_q.sel == WB_SEL_MEM);

   // Synchronous dmem only presents data in the first WB cycle; freeze it across a stall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
      end else if (flush || !stall) begin
         hold_valid <= 1'b0;
         hold_data  <= '0;
      end else if (wb_is_load && !hold_valid) begin
         hold_valid <= 1'b1;
         hold_data  <= dmem_rdata;
      end
   end

   assign load_rdata = hold_valid ? hold_data : dmem_rdata;

   ama_riscv_load_align u_load_align (
      .funct3     (wb_q.funct3),
      .offset     (wb_q.alu[1:0]),
      .rdata      (load_rdata),
      .data       (load_data),
      .misaligned (load_mis_raw)
   );

   assign load_misaligned = wb_is_load & load_mis_raw;

   always_comb begin
      rf_data_d = '0;
      case (wb_q.sel)
         WB_SEL_ALU: rf_data_d = wb_q.alu;
         WB_SEL_MEM: rf_data_d = load_data;
         WB_SEL_PC4: rf_data_d = wb_q.pc + 32'd4;
         default:    rf_data_d = '0;
      endcase
   end

   assign rf_we     = wb_q.valid & wb_q.rd_we & (wb_q.rd_addr != RF_X0) & ~load_misaligned;
   assign rf_addr_d = wb_q.rd_addr;

`ifdef AMA_RISCV_WB_INSTRET_EN
   logic [63:0] instret_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         instret_q <= '0;
      else if (wb_q.valid && !stall && !flush)
         instret_q <= instret_q + 64'd1;
   end

   assign instret = instret_q;
`else
   assign instret = 64'h0;
`endif

endmodule
